// File: rtl/pipo_univ_shift.sv
// pipo_univ_shift: parallel-in/parallel-out universal shift register with an LSB-first serialize burst
module pipo_univ_shift #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [WIDTH-1:0] pi,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] po,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] nxt;

    assign sout = po[0];

    // idle-state mode decode: value po takes when en is high and no burst is requested
    always_comb begin
        nxt = po;
        case (mode)
            3'b001:  nxt = pi;
            3'b010:  nxt = {po[WIDTH-2:0], sin_l};
            3'b011:  nxt = {sin_r, po[WIDTH-1:1]};
            3'b100:  nxt = {po[WIDTH-2:0], po[WIDTH-1]};
            3'b101:  nxt = {po[0], po[WIDTH-1:1]};
            3'b110:  nxt = ~po;
            3'b111:  nxt = '0;
            default: nxt = po;
        endcase
    end

    // burst FSM and data register; start wins over mode in IDLE, everything but sin_r is ignored in SHIFT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            po    <= RST_VAL;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                po    <= pi;
                cnt   <= CW'(WIDTH - 1);
                state <= SHIFT;
                busy  <= 1'b1;
            end else if (en) begin
                po <= nxt;
            end
        end else begin
            po <= {sin_r, po[WIDTH-1:1]};
            if (cnt == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule
